timing_sequencer: RTL and testbench

Parametrised instruction-cycle timing generator for the multi-cycle CPU. It sequences a configurable number of fetch beats and a per-instruction variable number of execute beats, one beat per memory/datapath `done` handshake. For each beat it emits a phase level (`m_if`/`m_ex`) and a single-cycle beat-entry pulse. It adds single-step mode and an end-of-instruction strobe, and sits between the front-panel/run control and the control-signal decoder.

---
 rtl/timing_pkg.sv | 21 ++
 rtl/beat_pulse_dec.sv | 29 ++
 rtl/timing_sequencer.sv | 143 ++++++++++++++
 tb/tb_timing_sequencer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/timing_pkg.sv
// Shared definitions for the instruction-cycle timing sequencer.
package timing_pkg;

    // Sequencer states; the encoding is visible on the state output.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StExec  = 2'd2,
        StPause = 2'd3
    } state_e;

    // Width of the beat index: wide enough for both phases, never below 1.
    function automatic int beat_w(input int cnt_w, input int if_beats);
        int w;
        w = cnt_w;
        if ($clog2(if_beats) > w) w = $clog2(if_beats);
        if (w < 1) w = 1;
        return w;
    endfunction

endpackage

// File: rtl/beat_pulse_dec.sv
// Registered binary-index to one-hot decoder; emits a one-cycle pulse on beat entry.
module beat_pulse_dec #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [IDX_W-1:0] idx,
    output logic [N-1:0]     pulse
);

    logic [N-1:0] pulse_d;

    // Decode the entered beat index; all zero when no entry this cycle.
    always_comb begin
        pulse_d = '0;
        for (int i = 0; i < N; i++) begin
            if (en && (idx == IDX_W'(i))) pulse_d[i] = 1'b1;
        end
    end

    // Register the pulse so it lines up with the registered state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pulse <= '0;
        else        pulse <= pulse_d;
    end

endmodule

// File: rtl/timing_sequencer.sv
// Fetch/execute beat sequencer with single-step pause and end-of-instruction strobe.
module timing_sequencer
    import timing_pkg::*;
#(
    parameter int IF_BEATS     = 2,
    parameter int EX_BEATS_MAX = 4,
    parameter int CNT_W        = (EX_BEATS_MAX > 1) ? $clog2(EX_BEATS_MAX) : 1
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   run,
    input  logic                                   stop,
    input  logic                                   step_mode,
    input  logic                                   step,
    input  logic                                   done,
    input  logic [CNT_W-1:0]                       ex_len,
    output logic                                   m_if,
    output logic                                   m_ex,
    output logic [IF_BEATS-1:0]                    if_pulse,
    output logic [EX_BEATS_MAX-1:0]                ex_pulse,
    output logic [beat_w(CNT_W, IF_BEATS)-1:0]     beat,
    output logic [1:0]                             state,
    output logic                                   instr_done
);

    localparam int BEAT_W = beat_w(CNT_W, IF_BEATS);
    localparam logic [CNT_W-1:0] EX_LAST = CNT_W'(EX_BEATS_MAX - 1);
    localparam logic [BEAT_W-1:0] IF_LAST = BEAT_W'(IF_BEATS - 1);

    state_e            state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic              if_en, ex_en, instr_done_d;

    // Next-state logic; if_en/ex_en flag entry into a new (or re-entered) beat.
    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        len_d        = len_q;
        if_en        = 1'b0;
        ex_en        = 1'b0;
        instr_done_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (run) begin
                    state_d = StFetch;
                    beat_d  = '0;
                    if_en   = 1'b1;
                end
            end
            StFetch: begin
                if (done) begin
                    if (beat_q == IF_LAST) begin
                        beat_d = '0;
                        if (stop) begin
                            state_d = StIdle;
                        end else begin
                            state_d = StExec;
                            ex_en   = 1'b1;
                            // Saturate for non-power-of-two execute depths.
                            len_d   = (ex_len > EX_LAST) ? EX_LAST : ex_len;
                        end
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                        if_en  = 1'b1;
                    end
                end
            end
            StExec: begin
                if (done) begin
                    if (beat_q == BEAT_W'(len_q)) begin
                        instr_done_d = 1'b1;
                        beat_d       = '0;
                        if (step_mode) begin
                            state_d = StPause;
                        end else begin
                            state_d = StFetch;
                            if_en   = 1'b1;
                        end
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                        ex_en  = 1'b1;
                    end
                end
            end
            StPause: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (step) begin
                    state_d = StFetch;
                    beat_d  = '0;
                    if_en   = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, beat counter, latched length and registered phase outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            beat_q     <= '0;
            len_q      <= '0;
            m_if       <= 1'b0;
            m_ex       <= 1'b0;
            instr_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            len_q      <= len_d;
            m_if       <= (state_d == StFetch);
            m_ex       <= (state_d == StExec);
            instr_done <= instr_done_d;
        end
    end

    assign state = state_q;
    assign beat  = beat_q;

    beat_pulse_dec #(
        .N     (IF_BEATS),
        .IDX_W (BEAT_W)
    ) u_if_dec (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (if_en),
        .idx   (beat_d),
        .pulse (if_pulse)
    );

    beat_pulse_dec #(
        .N     (EX_BEATS_MAX),
        .IDX_W (BEAT_W)
    ) u_ex_dec (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (ex_en),
        .idx   (beat_d),
        .pulse (ex_pulse)
    );

endmodule

// File: tb/tb_timing_sequencer.sv
// Self-checking bench: expectations queued per driven cycle, compared after the edge.
module tb_timing_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Default instance: IF_BEATS=2, EX_BEATS_MAX=4.
    logic       run1, stop1, sm1, step1, done1;
    logic [1:0] len1;
    logic       m_if1, m_ex1, idn1;
    logic [1:0] ifp1;
    logic [3:0] exp1;
    logic [1:0] beat1;
    logic [1:0] state1;

    // Second instance: IF_BEATS=3, EX_BEATS_MAX=6.
    logic       run2, stop2, sm2, step2, done2;
    logic [2:0] len2;
    logic       m_if2, m_ex2, idn2;
    logic [2:0] ifp2;
    logic [5:0] exp2;
    logic [2:0] beat2;
    logic [1:0] state2;

    timing_sequencer dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run1),
        .stop       (stop1),
        .step_mode  (sm1),
        .step       (step1),
        .done       (done1),
        .ex_len     (len1),
        .m_if       (m_if1),
        .m_ex       (m_ex1),
        .if_pulse   (ifp1),
        .ex_pulse   (exp1),
        .beat       (beat1),
        .state      (state1),
        .instr_done (idn1)
    );

    timing_sequencer #(
        .IF_BEATS     (3),
        .EX_BEATS_MAX (6)
    ) dut2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run2),
        .stop       (stop2),
        .step_mode  (sm2),
        .step       (step2),
        .done       (done2),
        .ex_len     (len2),
        .m_if       (m_if2),
        .m_ex       (m_ex2),
        .if_pulse   (ifp2),
        .ex_pulse   (exp2),
        .beat       (beat2),
        .state      (state2),
        .instr_done (idn2)
    );

    typedef struct packed {
        logic       sel;
        logic [1:0] st;
        logic [2:0] bt;
        logic [7:0] ifp;
        logic [7:0] exq;
        logic       idn;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_checks++;
        if (obs !== req) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, req);
        else             n_pass++;
    endtask

    // Drive one cycle of inputs to the selected DUT and queue the post-edge expectation.
    task automatic drive(input logic sel, input logic r, input logic s, input logic sm,
                         input logic sp, input logic d, input logic [2:0] len, input string tag,
                         input logic [1:0] st, input logic [2:0] bt, input logic [7:0] ifp,
                         input logic [7:0] exq, input logic idn);
        exp_t e;
        @(negedge clk);
        if (!sel) begin
            run1 = r; stop1 = s; sm1 = sm; step1 = sp; done1 = d; len1 = len[1:0];
            run2 = 0; stop2 = 0; sm2 = 0; step2 = 0; done2 = 0; len2 = 0;
        end else begin
            run2 = r; stop2 = s; sm2 = sm; step2 = sp; done2 = d; len2 = len;
            run1 = 0; stop1 = 0; sm1 = 0; step1 = 0; done1 = 0; len1 = 0;
        end
        e.sel = sel; e.st = st; e.bt = bt; e.ifp = ifp; e.exq = exq; e.idn = idn;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    exp_t  mon_e;
    string mon_t;

    // Scoreboard: compare each queued expectation just after its edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_t = tag_q.pop_front();
            if (!mon_e.sel) begin
                check_eq({mon_t, ".state"}, 32'(state1), 32'(mon_e.st));
                check_eq({mon_t, ".beat"},  32'(beat1),  32'(mon_e.bt));
                check_eq({mon_t, ".m_if"},  32'(m_if1),  32'(mon_e.st == 2'd1));
                check_eq({mon_t, ".m_ex"},  32'(m_ex1),  32'(mon_e.st == 2'd2));
                check_eq({mon_t, ".if_pulse"}, 32'(ifp1), 32'(mon_e.ifp));
                check_eq({mon_t, ".ex_pulse"}, 32'(exp1), 32'(mon_e.exq));
                check_eq({mon_t, ".instr_done"}, 32'(idn1), 32'(mon_e.idn));
            end else begin
                check_eq({mon_t, ".state"}, 32'(state2), 32'(mon_e.st));
                check_eq({mon_t, ".beat"},  32'(beat2),  32'(mon_e.bt));
                check_eq({mon_t, ".m_if"},  32'(m_if2),  32'(mon_e.st == 2'd1));
                check_eq({mon_t, ".m_ex"},  32'(m_ex2),  32'(mon_e.st == 2'd2));
                check_eq({mon_t, ".if_pulse"}, 32'(ifp2), 32'(mon_e.ifp));
                check_eq({mon_t, ".ex_pulse"}, 32'(exp2), 32'(mon_e.exq));
                check_eq({mon_t, ".instr_done"}, 32'(idn2), 32'(mon_e.idn));
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check_eq({tag, ".outs1"}, {22'd0, state1, beat1, m_if1, m_ex1, ifp1, exp1, idn1}, 32'd0);
        check_eq({tag, ".outs2"}, {18'd0, state2, beat2, m_if2, m_ex2, ifp2, exp2, idn2}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        run1 = 0; stop1 = 0; sm1 = 0; step1 = 0; done1 = 0; len1 = 0;
        run2 = 0; stop2 = 0; sm2 = 0; step2 = 0; done2 = 0; len2 = 0;
        repeat (3) @(posedge clk);
        #2;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back beats with done held high, then stop after last fetch beat.
        drive(0, 1, 0, 0, 0, 1, 3, "t1.f0",   1, 0, 8'h1, 8'h0, 0);
        drive(0, 0, 0, 0, 0, 1, 3, "t1.f1",   1, 1, 8'h2, 8'h0, 0);
        drive(0, 0, 0, 0, 0, 1, 3, "t1.e0",   2, 0, 8'h0, 8'h1, 0);
        drive(0, 0, 0, 0, 0, 1, 3, "t1.e1",   2, 1, 8'h0, 8'h2, 0);
        drive(0, 0, 0, 0, 0, 1, 3, "t1.e2",   2, 2, 8'h0, 8'h4, 0);
        drive(0, 0, 0, 0, 0, 1, 3, "t1.e3",   2, 3, 8'h0, 8'h8, 0);
        drive(0, 0, 0, 0, 0, 1, 3, "t1.wrap", 1, 0, 8'h1, 8'h0, 1);
        drive(0, 0, 0, 0, 0, 1, 3, "t1.f1b",  1, 1, 8'h2, 8'h0, 0);
        drive(0, 0, 1, 0, 0, 1, 3, "t3.stop", 0, 0, 8'h0, 8'h0, 0);
        drive(0, 0, 0, 0, 0, 1, 3, "t3.idle", 0, 0, 8'h0, 8'h0, 0);

        // Three-cycle beats, single execute beat.
        drive(0, 1, 0, 0, 0, 0, 0, "t2.f0",   1, 0, 8'h1, 8'h0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, "t2.f0h",  1, 0, 8'h0, 8'h0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, "t2.f0h2", 1, 0, 8'h0, 8'h0, 0);
        drive(0, 0, 0, 0, 0, 1, 0, "t2.f1",   1, 1, 8'h2, 8'h0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, "t2.f1h",  1, 1, 8'h0, 8'h0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, "t2.f1h2", 1, 1, 8'h0, 8'h0, 0);
        drive(0, 0, 0, 0, 0, 1, 0, "t2.e0",   2, 0, 8'h0, 8'h1, 0);
        drive(0, 0, 0, 0, 0, 0, 0, "t2.e0h",  2, 0, 8'h0, 8'h0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, "t2.e0h2", 2, 0, 8'h0, 8'h0, 0);
        drive(0, 0, 0, 0, 0, 1, 0, "t2.wrap", 1, 0, 8'h1, 8'h0, 1);
        drive(0, 0, 0, 0, 0, 1, 0, "t2.f1b",  1, 1, 8'h2, 8'h0, 0);
        drive(0, 0, 1, 0, 0, 1, 0, "t2.stop", 0, 0, 8'h0, 8'h0, 0);

        // Single-step mode: pause, done ignored, step resumes, stop beats step.
        drive(0, 1, 0, 1, 0, 1, 1, "t4.f0",    1, 0, 8'h1, 8'h0, 0);
        drive(0, 0, 0, 1, 0, 1, 1, "t4.f1",    1, 1, 8'h2, 8'h0, 0);
        drive(0, 0, 0, 1, 0, 1, 1, "t4.e0",    2, 0, 8'h0, 8'h1, 0);
        drive(0, 0, 0, 1, 0, 1, 1, "t4.e1",    2, 1, 8'h0, 8'h2, 0);
        drive(0, 0, 0, 1, 0, 1, 1, "t4.pause", 3, 0, 8'h0, 8'h0, 1);
        drive(0, 0, 0, 1, 0, 1, 1, "t4.pdone", 3, 0, 8'h0, 8'h0, 0);
        drive(0, 0, 0, 1, 1, 0, 1, "t4.step",  1, 0, 8'h1, 8'h0, 0);
        drive(0, 0, 0, 1, 0, 1, 1, "t4.f1b",   1, 1, 8'h2, 8'h0, 0);
        drive(0, 0, 0, 1, 0, 1, 1, "t4.e0b",   2, 0, 8'h0, 8'h1, 0);
        drive(0, 0, 0, 1, 0, 1, 1, "t4.e1b",   2, 1, 8'h0, 8'h2, 0);
        drive(0, 0, 0, 1, 0, 1, 1, "t4.pauseb", 3, 0, 8'h0, 8'h0, 1);
        drive(0, 0, 1, 1, 1, 0, 1, "t4.ststop", 0, 0, 8'h0, 8'h0, 0);

        // Non-power-of-two depth: ex_len=7 saturates to six execute beats.
        drive(1, 1, 0, 0, 0, 1, 7, "t5.f0",   1, 0, 8'h01, 8'h00, 0);
        drive(1, 0, 0, 0, 0, 1, 7, "t5.f1",   1, 1, 8'h02, 8'h00, 0);
        drive(1, 0, 0, 0, 0, 1, 7, "t5.f2",   1, 2, 8'h04, 8'h00, 0);
        drive(1, 0, 0, 0, 0, 1, 7, "t5.e0",   2, 0, 8'h00, 8'h01, 0);
        drive(1, 0, 0, 0, 0, 1, 7, "t5.e1",   2, 1, 8'h00, 8'h02, 0);
        drive(1, 0, 0, 0, 0, 1, 7, "t5.e2",   2, 2, 8'h00, 8'h04, 0);
        drive(1, 0, 0, 0, 0, 1, 7, "t5.e3",   2, 3, 8'h00, 8'h08, 0);
        drive(1, 0, 0, 0, 0, 1, 7, "t5.e4",   2, 4, 8'h00, 8'h10, 0);
        drive(1, 0, 0, 0, 0, 1, 7, "t5.e5",   2, 5, 8'h00, 8'h20, 0);
        drive(1, 0, 0, 0, 0, 1, 7, "t5.wrap", 1, 0, 8'h01, 8'h00, 1);
        drive(1, 0, 0, 0, 0, 1, 7, "t5.f1b",  1, 1, 8'h02, 8'h00, 0);
        drive(1, 0, 0, 0, 0, 1, 7, "t5.f2b",  1, 2, 8'h04, 8'h00, 0);
        drive(1, 0, 1, 0, 0, 1, 7, "t5.stop", 0, 0, 8'h00, 8'h00, 0);

        // Asynchronous reset in the middle of execute beat 2, then restart.
        drive(0, 1, 0, 0, 0, 1, 3, "t6.f0",  1, 0, 8'h1, 8'h0, 0);
        drive(0, 0, 0, 0, 0, 1, 3, "t6.f1",  1, 1, 8'h2, 8'h0, 0);
        drive(0, 0, 0, 0, 0, 1, 3, "t6.e0",  2, 0, 8'h0, 8'h1, 0);
        drive(0, 0, 0, 0, 0, 1, 3, "t6.e1",  2, 1, 8'h0, 8'h2, 0);
        drive(0, 0, 0, 0, 0, 1, 3, "t6.e2",  2, 2, 8'h0, 8'h4, 0);
        drive(0, 0, 0, 0, 0, 0, 3, "t6.e2h", 2, 2, 8'h0, 8'h0, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("t6.async");
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 1, 0, 0, 0, 0, 3, "t6.restart", 1, 0, 8'h1, 8'h0, 0);
        drive(0, 0, 0, 0, 0, 0, 3, "t6.hold",    1, 0, 8'h0, 8'h0, 0);

        repeat (2) @(posedge clk);
        #2;
        if (exp_q.size() != 0) check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
